// File: rtl/dma_periph_pkg.sv
// dma_periph_pkg: shared constants and FSM encoding for the DMA peripheral request front-end
package dma_periph_pkg;
   localparam int   MAX_CH     = 32;
   localparam logic MODE_PULSE = 1'b0;
   localparam logic MODE_LEVEL = 1'b1;
   typedef enum logic {IDLE, OFFER} state_e;
endpackage

// File: rtl/dma_rr_arb.sv
// dma_rr_arb: combinational round-robin picker, searching upward from ptr_i with wrap-around
module dma_rr_arb #(
   parameter int N    = 8,
   localparam int CH_W = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [CH_W-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [CH_W-1:0] idx_o,
   output logic            any_o
);
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
            any_o = 1'b1;
            idx_o = CH_W'((int'(ptr_i) + i) % N);
         end
      end
      gnt_o = any_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
   end
endmodule

// File: rtl/dma_periph_req_arb.sv
// dma_periph_req_arb: per-channel request capture (pulse counting or level), round-robin grant
// offer over valid/ready, busy tracking and one-cycle clear pulses on completion
module dma_periph_req_arb
   import dma_periph_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 4,
   localparam int CH_W  = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] ch_mode,
   input  logic [NUM_CH-1:0] periph_req,
   output logic [NUM_CH-1:0] periph_clr,
   output logic              grant_valid,
   output logic [CH_W-1:0]   grant_ch,
   input  logic              grant_ready,
   input  logic              done_valid,
   input  logic [CH_W-1:0]   done_ch,
   output logic [NUM_CH-1:0] pend_ovf,
   output logic [NUM_CH-1:0] busy
);
   logic [NUM_CH-1:0] req_q, req_prev_q, busy_q, busy_d, ovf_q, ovf_d, clr_q, clr_d;
   logic [NUM_CH-1:0] gnt_oh_q, gnt_oh_d, elig, win_oh;
   logic [CNT_W-1:0]  pend_q [NUM_CH];
   logic [CNT_W-1:0]  pend_d [NUM_CH];
   logic [CH_W-1:0]   ptr_q, ptr_d, gnt_ch_q, gnt_ch_d, win_idx;
   logic              win_any, accept, inc, dec;
   state_e            state_q, state_d;

   dma_rr_arb #(.N(NUM_CH)) u_arb (
      .req_i(elig),
      .ptr_i(ptr_q),
      .gnt_o(win_oh),
      .idx_o(win_idx),
      .any_o(win_any)
   );

   assign accept = (state_q == OFFER) && grant_ready;

   always_comb begin
      state_d  = state_q;
      gnt_ch_d = gnt_ch_q;
      gnt_oh_d = gnt_oh_q;
      ptr_d    = ptr_q;
      busy_d   = busy_q;
      ovf_d    = ovf_q;
      clr_d    = '0;
      pend_d   = pend_q;
      elig     = '0;
      inc      = 1'b0;
      dec      = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         elig[c] = ch_en[c] & ~busy_q[c] & ((ch_mode[c] == MODE_LEVEL) ? req_q[c] : |pend_q[c]);
         // Edges are taken on the registered request so pulse requests see one extra stage
         inc = (ch_mode[c] == MODE_PULSE) & req_q[c] & ~req_prev_q[c];
         dec = accept & gnt_oh_q[c];
         if (ch_mode[c] == MODE_LEVEL) pend_d[c] = '0;
         else if (inc && !dec && &pend_q[c]) ovf_d[c] = 1'b1;
         else if (inc && !dec) pend_d[c] = pend_q[c] + 1'b1;
         else if (dec && !inc && |pend_q[c]) pend_d[c] = pend_q[c] - 1'b1;
      end
      if (done_valid && busy_q[done_ch]) begin
         busy_d[done_ch] = 1'b0;
         clr_d[done_ch]  = 1'b1;
      end
      if (state_q == IDLE && win_any) begin
         state_d  = OFFER;
         gnt_ch_d = win_idx;
         gnt_oh_d = win_oh;
      end
      // Set after the done clear so a same-cycle done for this channel leaves it busy
      if (accept) begin
         state_d = IDLE;
         busy_d  = busy_d | gnt_oh_q;
         ptr_d   = (gnt_ch_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         req_q      <= '0;
         req_prev_q <= '0;
         busy_q     <= '0;
         ovf_q      <= '0;
         clr_q      <= '0;
         gnt_oh_q   <= '0;
         gnt_ch_q   <= '0;
         ptr_q      <= '0;
         pend_q     <= '{default: '0};
      end else begin
         state_q    <= state_d;
         req_q      <= periph_req;
         req_prev_q <= req_q;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
         clr_q      <= clr_d;
         gnt_oh_q   <= gnt_oh_d;
         gnt_ch_q   <= gnt_ch_d;
         ptr_q      <= ptr_d;
         pend_q     <= pend_d;
      end
   end

   assign periph_clr  = clr_q;
   assign grant_valid = (state_q == OFFER);
   assign grant_ch    = gnt_ch_q;
   assign pend_ovf    = ovf_q;
   assign busy        = busy_q;
endmodule

// File: tb/tb_dma_periph_req_arb.sv
// tb_dma_periph_req_arb: directed checks of capture, round-robin, concurrency, overflow and reset
module tb_dma_periph_req_arb;
   logic       clk = 1'b0;
   logic       reset, grant_valid, grant_ready, done_valid;
   logic [7:0] ch_en, ch_mode, periph_req, periph_clr, pend_ovf, busy;
   logic [2:0] grant_ch, done_ch;
   int         vecs = 0;
   int         errs = 0;
   int         grants;
   int         rr_exp[4] = '{1, 4, 6, 1};

   dma_periph_req_arb #(.NUM_CH(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .ch_en(ch_en), .ch_mode(ch_mode), .periph_req(periph_req),
      .periph_clr(periph_clr), .grant_valid(grant_valid), .grant_ch(grant_ch),
      .grant_ready(grant_ready), .done_valid(done_valid), .done_ch(done_ch),
      .pend_ovf(pend_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gv(input int max);
      for (int k = 0; k < max && !grant_valid; k++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1; ch_en = '0; ch_mode = '0; periph_req = '0;
      grant_ready = 1'b0; done_valid = 1'b0; done_ch = '0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      step();
      chk("rst_gv", grant_valid, 0);
      chk("rst_ch", grant_ch, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", pend_ovf, 0);
      chk("rst_clr", periph_clr, 0);

      // single pulse on ch3
      ch_en = 8'h08;
      periph_req = 8'h08; step();
      periph_req = 8'h00; step();
      chk("p_gv_early", grant_valid, 0);
      step();
      chk("p_gv", grant_valid, 1);
      chk("p_ch", grant_ch, 3);
      grant_ready = 1'b1; step(); grant_ready = 1'b0;
      chk("p_busy", busy, 8'h08);
      chk("p_gv_drop", grant_valid, 0);
      done_valid = 1'b1; done_ch = 3'd3; step(); done_valid = 1'b0;
      chk("p_clr", periph_clr, 8'h08);
      chk("p_busy0", busy, 0);
      step();
      chk("p_clr1", periph_clr, 0);
      step(); step();
      chk("p_noregrant", grant_valid, 0);

      // reset with ch2 busy and ch1 offered
      do_reset();
      ch_en = 8'h06; ch_mode = 8'h06; periph_req = 8'h04;
      wait_gv(5);
      chk("r_ch2", grant_ch, 2);
      grant_ready = 1'b1; step(); grant_ready = 1'b0;
      periph_req = 8'h02;
      wait_gv(5);
      chk("r_offer", {busy, grant_valid, grant_ch}, {8'h04, 1'b1, 3'd1});
      reset = 1'b1; done_valid = 1'b1; done_ch = 3'd2; step();
      reset = 1'b0; done_valid = 1'b0; periph_req = '0; ch_en = '0;
      chk("r_all0", {periph_clr, grant_valid, grant_ch, busy, pend_ovf}, 0);
      step();
      chk("r_noclr", {periph_clr, grant_valid}, 0);

      // queueing: 17 pulses on disabled ch0, then drain
      do_reset();
      for (int p = 0; p < 15; p++) begin
         periph_req = 8'h01; step();
         periph_req = 8'h00; step();
      end
      step();
      chk("q_ovf15", pend_ovf, 0);
      for (int p = 0; p < 2; p++) begin
         periph_req = 8'h01; step();
         periph_req = 8'h00; step();
      end
      step();
      chk("q_ovf17", pend_ovf, 8'h01);
      chk("q_dis_gv", grant_valid, 0);
      ch_en = 8'h01;
      grants = 0;
      for (int g = 0; g < 20; g++) begin
         wait_gv(6);
         if (!grant_valid) break;
         chk("q_ch", grant_ch, 0);
         grant_ready = 1'b1; step(); grant_ready = 1'b0;
         done_valid = 1'b1; done_ch = 3'd0; step(); done_valid = 1'b0;
         grants++;
      end
      chk("q_grants", grants, 15);
      chk("q_ovf_sticky", pend_ovf, 8'h01);

      // round-robin among level channels 1/4/6
      do_reset();
      ch_en = 8'h52; ch_mode = 8'h52; periph_req = 8'h52;
      for (int r = 0; r < 4; r++) begin
         wait_gv(6);
         chk("rr_gv", grant_valid, 1);
         chk("rr_ch", grant_ch, rr_exp[r]);
         grant_ready = 1'b1; step(); grant_ready = 1'b0;
         done_valid = 1'b1; done_ch = 3'(rr_exp[r]); step(); done_valid = 1'b0;
         chk("rr_clr", periph_clr, 32'(1) << rr_exp[r]);
      end

      // concurrency: ch1 and ch2 busy together, out-of-order dones, stray done
      do_reset();
      ch_en = 8'h06; ch_mode = 8'h06; periph_req = 8'h02;
      wait_gv(6);
      chk("c_ch1", grant_ch, 1);
      grant_ready = 1'b1; step(); grant_ready = 1'b0;
      periph_req = 8'h04;
      wait_gv(6);
      chk("c_ch2", {grant_valid, grant_ch}, {1'b1, 3'd2});
      grant_ready = 1'b1; step(); grant_ready = 1'b0;
      periph_req = 8'h00;
      chk("c_busy", busy, 8'h06);
      done_valid = 1'b1; done_ch = 3'd2; step();
      chk("c_clr2", {periph_clr, busy}, {8'h04, 8'h02});
      done_ch = 3'd1; step();
      chk("c_clr1", {periph_clr, busy}, {8'h02, 8'h00});
      done_ch = 3'd5; step();
      chk("c_stray", periph_clr, 0);
      done_valid = 1'b0; step();
      chk("c_quiet", {periph_clr, grant_valid}, 0);

      // stable offer while ready low, ch_en removed mid-offer
      do_reset();
      ch_en = 8'h01; ch_mode = 8'h01; periph_req = 8'h01;
      wait_gv(6);
      for (int s = 0; s < 10; s++) begin
         chk("s_hold", {grant_valid, grant_ch}, {1'b1, 3'd0});
         if (s == 3) ch_en = 8'h00;
         step();
      end
      chk("s_hold_end", {grant_valid, grant_ch}, {1'b1, 3'd0});
      grant_ready = 1'b1; step(); grant_ready = 1'b0;
      chk("s_acc", {grant_valid, busy}, {1'b0, 8'h01});
      done_valid = 1'b1; done_ch = 3'd0; step(); done_valid = 1'b0;
      chk("s_clr", periph_clr, 8'h01);
      step(); step(); step();
      chk("s_noregrant", {grant_valid, busy}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
